operand_fetch_stage: RTL and testbench

//  Pipeline stage directly upstream of the ALU. Accepts a 16-bit instruction from fetch and decodes
//  its register fields. Reads rn/rm from an 8x16 register file and registers {instr, rn, rm, rd_addr}
//  for the ALU. Owns the register file write port for writeback and stalls on read-after-write hazards

---
 rtl/tsp16_pkg.sv | 50 +++++
 rtl/register_file.sv | 37 +++
 rtl/operand_fetch_stage.sv | 110 +++++++++++
 tb/tb_operand_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tsp16_pkg.sv
// Shared definitions for the 16-bit operand fetch stage: instruction field
// layout, condition/opcode encodings and register/word types.
package tsp16_pkg;

  localparam int unsigned TSP_DATA_W   = 16;
  localparam int unsigned TSP_NUM_REGS = 8;
  localparam int unsigned REG_AW       = $clog2(TSP_NUM_REGS);

  typedef logic [REG_AW-1:0]     reg_idx_t;
  typedef logic [TSP_DATA_W-1:0] word_t;

  localparam int unsigned COND_MSB = 15;
  localparam int unsigned COND_LSB = 14;
  localparam int unsigned OP_MSB   = 13;
  localparam int unsigned OP_LSB   = 9;
  localparam int unsigned RD_MSB   = 8;
  localparam int unsigned RD_LSB   = 6;
  localparam int unsigned RN_MSB   = 5;
  localparam int unsigned RN_LSB   = 3;
  localparam int unsigned RM_MSB   = 2;
  localparam int unsigned RM_LSB   = 0;

  // Only this condition class writes a destination register.
  localparam logic [1:0] A_TYPE = 2'b00;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_EQUAL = 5'd1,
    ALU_OR    = 5'd2,
    ALU_AND   = 5'd3,
    ALU_MINUS = 5'd4
  } alu_op_e;

  function automatic logic [1:0] instr_cond(input word_t instr);
    return instr[COND_MSB:COND_LSB];
  endfunction

  function automatic reg_idx_t instr_rd(input word_t instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic reg_idx_t instr_rn(input word_t instr);
    return instr[RN_MSB:RN_LSB];
  endfunction

  function automatic reg_idx_t instr_rm(input word_t instr);
    return instr[RM_MSB:RM_LSB];
  endfunction

endpackage

// File: rtl/register_file.sv
// Register file: two combinational read ports with same-cycle write bypass,
// one synchronous write port, synchronous reset of every entry to zero.
module register_file
  import tsp16_pkg::*;
#(
  parameter int unsigned DATA_W   = TSP_DATA_W,
  parameter int unsigned NUM_REGS = TSP_NUM_REGS,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A read of the entry being written sees the new value, never the stale one.
  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage ahead of the ALU: decodes register fields, reads operands,
// tracks pending writes and stalls on read-after-write hazards.
module operand_fetch_stage
  import tsp16_pkg::*;
#(
  parameter int unsigned DATA_W   = TSP_DATA_W,
  parameter int unsigned NUM_REGS = TSP_NUM_REGS,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [DATA_W-1:0] out_rn,
  output logic [DATA_W-1:0] out_rm,
  output logic [AW-1:0]     out_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [AW-1:0]       rd_idx, rn_idx, rm_idx;
  logic [DATA_W-1:0]   rn_data, rm_data;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                rn_wb_hit, rm_wb_hit, hazard, accept, consume, is_writer;

  logic              out_valid_q;
  logic [15:0]       out_instr_q;
  logic [DATA_W-1:0] out_rn_q, out_rm_q;
  logic [AW-1:0]     out_rd_q;

  assign rd_idx    = instr_rd(in_instr);
  assign rn_idx    = instr_rn(in_instr);
  assign rm_idx    = instr_rm(in_instr);
  assign is_writer = (instr_cond(in_instr) == A_TYPE);

  register_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rn_idx),
    .rdata_a_o (rn_data),
    .raddr_b_i (rm_idx),
    .rdata_b_o (rm_data)
  );

  // A same-cycle writeback to a pending source resolves the hazard via the bypass.
  always_comb begin
    rn_wb_hit = wb_en & (wb_addr == rn_idx);
    rm_wb_hit = wb_en & (wb_addr == rm_idx);
    hazard    = in_valid & ((pending_q[rn_idx] & ~rn_wb_hit) |
                            (pending_q[rm_idx] & ~rm_wb_hit));
    in_ready  = ~hazard & (~out_valid_q | out_ready);
    accept    = in_valid & in_ready;
    consume   = out_valid_q & out_ready;
  end

  // Clear before set so a new writer to the index being written back stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (accept && is_writer) begin
      pending_d[rd_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_rn_q    <= '0;
      out_rm_q    <= '0;
      out_rd_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_instr_q <= in_instr;
      out_rn_q    <= rn_data;
      out_rm_q    <= rm_data;
      out_rd_q    <= rd_idx;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_rn    = out_rn_q;
  assign out_rm    = out_rm_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_operand_fetch_stage;
  import tsp16_pkg::*;

  localparam logic [1:0] NA = 2'b01;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [15:0] out_rn;
  logic [15:0] out_rm;
  logic [2:0]  out_rd;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(
    .DATA_W   (16),
    .NUM_REGS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_rn    (out_rn),
    .out_rm    (out_rm),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] c, input logic [4:0] op,
                                     input logic [2:0] rd, input logic [2:0] rn,
                                     input logic [2:0] rm);
    return {c, op, rd, rn, rm};
  endfunction

  // Inputs change 1 time unit after the active edge; directed checks land 4 units later.
  task automatic drive(input logic r, input logic iv, input logic [15:0] ins,
                       input logic ordy, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd);
    @(posedge clk);
    #1;
    rst = r; in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #3;
  endtask

  // Behavioural model: architectural registers, pending-write set, one output slot.
  logic [15:0] m_regs [8];
  bit          m_pend [8];
  bit          m_known = 0;
  logic        m_ov;
  logic [15:0] m_instr, m_rn, m_rm;
  logic [2:0]  m_rd;

  always @(negedge clk) begin
    logic [2:0]  rn, rm, rd;
    logic [15:0] vn, vm;
    bit          hz, er, acc, cons;
    rd = in_instr[8:6];
    rn = in_instr[5:3];
    rm = in_instr[2:0];
    vn = (wb_en && wb_addr == rn) ? wb_data : m_regs[rn];
    vm = (wb_en && wb_addr == rm) ? wb_data : m_regs[rm];
    hz = in_valid && ((m_pend[rn] && !(wb_en && wb_addr == rn)) ||
                      (m_pend[rm] && !(wb_en && wb_addr == rm)));
    er = !hz && (!m_ov || out_ready);
    if (m_known) begin
      chk("m_out_valid", {15'd0, out_valid}, {15'd0, m_ov});
      chk("m_out_instr", out_instr, m_instr);
      chk("m_out_rn", out_rn, m_rn);
      chk("m_out_rm", out_rm, m_rm);
      chk("m_out_rd", {13'd0, out_rd}, {13'd0, m_rd});
      chk("m_in_ready", {15'd0, in_ready}, {15'd0, er});
    end
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
      m_ov = 0; m_instr = '0; m_rn = '0; m_rm = '0; m_rd = '0;
      m_known = 1;
    end else if (m_known) begin
      acc  = in_valid && er;
      cons = m_ov && out_ready;
      if (acc) begin
        m_ov = 1; m_instr = in_instr; m_rn = vn; m_rm = vm; m_rd = rd;
      end else if (cons) begin
        m_ov = 0;
      end
      if (wb_en) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 0;
      end
      if (acc && in_instr[15:14] == A_TYPE) m_pend[rd] = 1;
    end
  end

  initial begin
    logic [15:0] i_add, i_or, i_and, i_w5, i_rd5, i_na6, i_rd6, i_w3, i_rd3;
    i_add = mk(A_TYPE, ALU_ADD,   3'd3, 3'd1, 3'd2);
    i_or  = mk(A_TYPE, ALU_OR,    3'd4, 3'd3, 3'd1);
    i_and = mk(A_TYPE, ALU_AND,   3'd5, 3'd1, 3'd2);
    i_w5  = mk(A_TYPE, ALU_ADD,   3'd5, 3'd0, 3'd0);
    i_rd5 = mk(A_TYPE, ALU_MINUS, 3'd7, 3'd5, 3'd0);
    i_na6 = mk(NA,     ALU_ADD,   3'd6, 3'd1, 3'd2);
    i_rd6 = mk(NA,     ALU_EQUAL, 3'd0, 3'd6, 3'd6);
    i_w3  = mk(A_TYPE, ALU_ADD,   3'd3, 3'd1, 3'd1);
    i_rd3 = mk(A_TYPE, ALU_AND,   3'd2, 3'd3, 3'd1);

    // 1: reset, load r1/r2, ADD r3,r1,r2
    drive(1, 0, '0, 1, 0, 0, '0);
    drive(1, 0, '0, 1, 0, 0, '0);
    drive(0, 0, '0, 1, 1, 3'd1, 16'h0005);
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_out_rn", out_rn, 16'h0000);
    drive(0, 0, '0, 1, 1, 3'd2, 16'h0003);
    drive(0, 1, i_add, 1, 0, 0, '0);
    chk("t1_in_ready", {15'd0, in_ready}, 16'd1);
    drive(0, 0, '0, 1, 0, 0, '0);
    chk("t1_out_valid", {15'd0, out_valid}, 16'd1);
    chk("t1_out_rn", out_rn, 16'h0005);
    chk("t1_out_rm", out_rm, 16'h0003);
    chk("t1_out_rd", {13'd0, out_rd}, 16'd3);
    chk("t1_out_instr", out_instr, i_add);

    // 2: RAW on r3 stalls until its writeback, which is bypassed
    drive(0, 1, i_or, 1, 0, 0, '0);
    chk("t2_stall0", {15'd0, in_ready}, 16'd0);
    drive(0, 1, i_or, 1, 0, 0, '0);
    chk("t2_stall1", {15'd0, in_ready}, 16'd0);
    drive(0, 1, i_or, 1, 1, 3'd3, 16'h0008);
    chk("t2_wb_release", {15'd0, in_ready}, 16'd1);
    drive(0, 0, '0, 0, 0, 0, '0);
    chk("t2_out_rn", out_rn, 16'h0008);
    chk("t2_out_rm", out_rm, 16'h0005);
    chk("t2_out_rd", {13'd0, out_rd}, 16'd4);

    // 3: downstream backpressure holds the bundle
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, i_and, 0, 0, 0, '0);
      chk("t3_hold_ready", {15'd0, in_ready}, 16'd0);
      chk("t3_hold_rn", out_rn, 16'h0008);
      chk("t3_hold_instr", out_instr, i_or);
    end
    drive(0, 1, i_and, 1, 0, 0, '0);
    chk("t3_release", {15'd0, in_ready}, 16'd1);
    drive(0, 0, '0, 1, 0, 0, '0);
    chk("t3_next_rn", out_rn, 16'h0005);
    chk("t3_next_rd", {13'd0, out_rd}, 16'd5);
    drive(0, 0, '0, 1, 0, 0, '0);
    chk("t3_drained", {15'd0, out_valid}, 16'd0);

    // 4: writer to r5 accepted alongside writeback to r5 keeps r5 pending
    drive(0, 1, i_w5, 1, 1, 3'd5, 16'h1234);
    chk("t4_accept", {15'd0, in_ready}, 16'd1);
    drive(0, 1, i_rd5, 1, 0, 0, '0);
    chk("t4_still_pending", {15'd0, in_ready}, 16'd0);
    chk("t4_out_rd", {13'd0, out_rd}, 16'd5);
    drive(0, 1, i_rd5, 1, 1, 3'd5, 16'h2222);
    chk("t4_release", {15'd0, in_ready}, 16'd1);
    drive(0, 0, '0, 1, 0, 0, '0);
    chk("t4_bypass_rn", out_rn, 16'h2222);

    // 5: non-writer does not mark its rd
    drive(0, 1, i_na6, 1, 0, 0, '0);
    chk("t5_accept", {15'd0, in_ready}, 16'd1);
    drive(0, 1, i_rd6, 1, 0, 0, '0);
    chk("t5_no_stall", {15'd0, in_ready}, 16'd1);
    drive(0, 0, '0, 1, 0, 0, '0);
    chk("t5_out_rn", out_rn, 16'h0000);
    chk("t5_out_rd", {13'd0, out_rd}, 16'd0);

    // 6: reset with a valid bundle and only r3 pending
    drive(0, 0, '0, 1, 1, 3'd4, 16'h4444);
    drive(0, 1, i_w3, 0, 1, 3'd7, 16'h7777);
    chk("t6_accept", {15'd0, in_ready}, 16'd1);
    drive(1, 0, '0, 0, 0, 0, '0);
    chk("t6_pre_valid", {15'd0, out_valid}, 16'd1);
    drive(0, 1, i_rd3, 1, 0, 0, '0);
    chk("t6_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("t6_rst_instr", out_instr, 16'h0000);
    chk("t6_rst_pending", {15'd0, in_ready}, 16'd1);
    drive(0, 0, '0, 1, 0, 0, '0);
    chk("t6_rst_r3", out_rn, 16'h0000);
    chk("t6_rst_r1", out_rm, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(99) == 0, $urandom_range(9) < 7, 16'($urandom),
            $urandom_range(3) != 0, $urandom_range(9) < 4, 3'($urandom_range(7)),
            16'($urandom));
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
